// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants and the state encoding of the bulk register-transfer sequencer.
package chip8_pkg;

  localparam int ADDR_W    = 12;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD,
    ST_LOAD_LAST,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/chip8_reg_transfer.sv
// FX55/FX65 sequencer: moves V0..Vx to or from memory at I, one byte per cycle,
// and hands back the advanced I (I + x + 1).
module chip8_reg_transfer #(
  parameter int ADDR_W = chip8_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic [3:0]        last_reg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] i_out,
  output logic              i_write_enable,
  output logic [3:0]        rf_read_select,
  input  logic [7:0]        rf_read_data,
  output logic              rf_write_enable,
  output logic [3:0]        rf_write_select,
  output logic [7:0]        rf_write_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_enable,
  output logic [7:0]        mem_write_data,
  input  logic [7:0]        mem_read_data
);
  import chip8_pkg::*;

  state_e                state_q, state_d;
  logic [REG_IDX_W-1:0]  idx_q, idx_d;
  logic [REG_IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  valid_q, valid_d;
  logic [ADDR_W-1:0]     cur_addr;

  assign cur_addr = base_q + ADDR_W'(idx_q);

  // NOTE: all state, including the latched operands, is cleared by the synchronous reset
  // so that no strobe can fire in the cycle after reset, even mid-transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      base_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      base_q  <= base_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    base_d  = base_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = last_reg;
          base_d  = base_addr;
          idx_d   = '0;
          state_d = load ? ST_LOAD : ST_STORE;
        end
      end
      ST_STORE: begin
        if (idx_q == last_q) state_d = ST_FINISH;
        else                 idx_d   = idx_q + 1'b1;
      end
      ST_LOAD: begin
        // The address issued now returns data next cycle.
        valid_d = 1'b1;
        if (idx_q == last_q) state_d = ST_LOAD_LAST;
        else                 idx_d   = idx_q + 1'b1;
      end
      ST_LOAD_LAST: state_d = ST_FINISH;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != ST_IDLE);
    done             = 1'b0;
    i_out            = '0;
    i_write_enable   = 1'b0;
    rf_read_select   = '0;
    rf_write_enable  = 1'b0;
    rf_write_select  = '0;
    rf_write_data    = '0;
    mem_addr         = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    unique case (state_q)
      ST_STORE: begin
        rf_read_select   = idx_q;
        mem_addr         = cur_addr;
        mem_write_enable = 1'b1;
        mem_write_data   = rf_read_data;
      end
      ST_LOAD: begin
        mem_addr = cur_addr;
        if (valid_q) begin
          rf_write_enable = 1'b1;
          rf_write_select = idx_q - 1'b1;
          rf_write_data   = mem_read_data;
        end
      end
      ST_LOAD_LAST: begin
        rf_write_enable = 1'b1;
        rf_write_select = last_q;
        rf_write_data   = mem_read_data;
      end
      ST_FINISH: begin
        done           = 1'b1;
        i_write_enable = 1'b1;
        i_out          = base_q + ADDR_W'(last_q) + ADDR_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_reg_transfer.sv
// Directed bench for chip8_reg_transfer with a behavioural register file and
// a 4 KB memory with one-cycle synchronous read.
module tb_chip8_reg_transfer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        load;
  logic [3:0]  last_reg;
  logic [11:0] base_addr;
  logic        busy, done, i_write_enable;
  logic [11:0] i_out, mem_addr;
  logic [3:0]  rf_read_select, rf_write_select;
  logic [7:0]  rf_read_data, rf_write_data, mem_write_data, mem_read_data;
  logic        rf_write_enable, mem_write_enable;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rf [16];
  logic [7:0]  mem [4096];
  int          rf_write_count = 0;

  // Bench-side backdoor write ports so each model has a single writing process.
  logic        tb_rf_we = 1'b0;
  logic [3:0]  tb_rf_sel = '0;
  logic [7:0]  tb_rf_wd = '0;
  logic        tb_mem_we = 1'b0;
  logic [11:0] tb_mem_addr = '0;
  logic [7:0]  tb_mem_wd = '0;

  always #5 clk = ~clk;

  chip8_reg_transfer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .load             (load),
    .last_reg         (last_reg),
    .base_addr        (base_addr),
    .busy             (busy),
    .done             (done),
    .i_out            (i_out),
    .i_write_enable   (i_write_enable),
    .rf_read_select   (rf_read_select),
    .rf_read_data     (rf_read_data),
    .rf_write_enable  (rf_write_enable),
    .rf_write_select  (rf_write_select),
    .rf_write_data    (rf_write_data),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  assign rf_read_data = rf[rf_read_select];

  always @(posedge clk) begin
    if (rf_write_enable) begin
      rf[rf_write_select] <= rf_write_data;
      rf_write_count      <= rf_write_count + 1;
    end else if (tb_rf_we) begin
      rf[tb_rf_sel] <= tb_rf_wd;
    end
  end

  always @(posedge clk) begin
    if (mem_write_enable)  mem[mem_addr]    <= mem_write_data;
    else if (tb_mem_we)    mem[tb_mem_addr] <= tb_mem_wd;
    mem_read_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_poke(input logic [3:0] sel, input logic [7:0] val);
    tb_rf_we = 1'b1; tb_rf_sel = sel; tb_rf_wd = val;
    tick();
    tb_rf_we = 1'b0;
  endtask

  task automatic mem_poke(input logic [11:0] a, input logic [7:0] val);
    tb_mem_we = 1'b1; tb_mem_addr = a; tb_mem_wd = val;
    tick();
    tb_mem_we = 1'b0;
  endtask

  // Start is sampled at edge 0; returns in cycle 1 with operands scrambled to prove latching.
  task automatic launch(input logic ld, input logic [3:0] x, input logic [11:0] base);
    load = ld; last_reg = x; base_addr = base; start = 1'b1;
    tick();
    start = 1'b0; load = ~ld; last_reg = x ^ 4'hA; base_addr = ~base;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " i_we"}, i_write_enable, 0);
    check({tag, " i_out"}, i_out, 0);
    check({tag, " rf_we"}, rf_write_enable, 0);
    check({tag, " mem_we"}, mem_write_enable, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " rf_rsel"}, rf_read_select, 0);
    check({tag, " rf_wsel"}, rf_write_select, 0);
  endtask

  initial begin
    logic [7:0]  st_data [4];
    logic [11:0] wrap_addr [4];
    int          cnt;
    st_data   = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    reset = 1'b0; start = 1'b0; load = 1'b0; last_reg = '0; base_addr = '0;
    tick(); tick();
    check_quiet("reset");
    reset = 1'b1;

    // Store V0..V3 to 0x300..0x303.
    for (int k = 0; k < 4; k++) rf_poke(4'(k), st_data[k]);
    launch(1'b0, 4'd3, 12'h300);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("store c%0d mem_we", k + 1), mem_write_enable, 1);
      check($sformatf("store c%0d addr", k + 1), mem_addr, 12'h300 + 12'(k));
      check($sformatf("store c%0d data", k + 1), mem_write_data, st_data[k]);
      check($sformatf("store c%0d done", k + 1), done, 0);
      tick();
    end
    check("store c5 done", done, 1);
    check("store c5 i_we", i_write_enable, 1);
    check("store c5 i_out", i_out, 12'h304);
    check("store c5 mem_we", mem_write_enable, 0);
    tick();
    check_quiet("store idle");
    check("store mem303", mem[12'h303], 8'h44);

    // Load V0..V2 from 0x200..0x202.
    mem_poke(12'h200, 8'hAA); mem_poke(12'h201, 8'hBB); mem_poke(12'h202, 8'hCC);
    launch(1'b1, 4'd2, 12'h200);
    check("load c1 rf_we", rf_write_enable, 0);
    check("load c1 addr", mem_addr, 12'h200);
    check("load c1 busy", busy, 1);
    tick();
    check("load c2 rf_we", rf_write_enable, 1);
    check("load c2 sel", rf_write_select, 0);
    check("load c2 data", rf_write_data, 8'hAA);
    tick();
    check("load c3 sel", rf_write_select, 1);
    check("load c3 data", rf_write_data, 8'hBB);
    tick();
    check("load c4 rf_we", rf_write_enable, 1);
    check("load c4 sel", rf_write_select, 2);
    check("load c4 data", rf_write_data, 8'hCC);
    check("load c4 done", done, 0);
    tick();
    check("load c5 done", done, 1);
    check("load c5 i_out", i_out, 12'h203);
    check("load c5 rf_we", rf_write_enable, 0);
    tick();
    check("load V2", rf[2], 8'hCC);

    // Address wrap.
    launch(1'b0, 4'd3, 12'hFFE);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap c%0d addr", k + 1), mem_addr, wrap_addr[k]);
      tick();
    end
    check("wrap i_out", i_out, 12'h002);
    tick();

    // x=0 store and load.
    launch(1'b0, 4'd0, 12'h400);
    check("x0 store c1 mem_we", mem_write_enable, 1);
    tick();
    check("x0 store c2 done", done, 1);
    check("x0 store c2 i_out", i_out, 12'h401);
    tick();
    launch(1'b1, 4'd0, 12'h200);
    check("x0 load c1 rf_we", rf_write_enable, 0);
    tick();
    check("x0 load c2 rf_we", rf_write_enable, 1);
    check("x0 load c2 data", rf_write_data, 8'hAA);
    tick();
    check("x0 load c3 done", done, 1);
    tick();

    // x=F load writes all sixteen registers.
    for (int k = 0; k < 16; k++) mem_poke(12'h800 + 12'(k), 8'h30 + 8'(k));
    cnt = rf_write_count;
    launch(1'b1, 4'hF, 12'h800);
    for (int c = 1; c <= 18; c++) begin
      check($sformatf("xF c%0d done", c), done, (c == 18) ? 1 : 0);
      if (c == 18) check("xF i_out", i_out, 12'h810);
      tick();
    end
    check("xF write count", rf_write_count - cnt, 16);
    for (int k = 0; k < 16; k++) check($sformatf("xF V%0d", k), rf[k], 8'h30 + 8'(k));

    // Start held through busy and FINISH is ignored.
    launch(1'b0, 4'd1, 12'h100);
    start = 1'b1; load = 1'b1; last_reg = 4'hF; base_addr = 12'h700;
    check("ign c1 addr", mem_addr, 12'h100);
    tick();
    check("ign c2 addr", mem_addr, 12'h101);
    tick();
    check("ign c3 done", done, 1);
    check("ign c3 i_out", i_out, 12'h102);
    tick();
    start = 1'b0;
    check("ign c4 busy", busy, 0);
    tick();
    check("ign c5 busy", busy, 0);

    // Reset in cycle 3 of an x=5 load.
    launch(1'b1, 4'd5, 12'h800);
    tick();
    tick();
    check("rst c3 rf_we", rf_write_enable, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_quiet("rst c4");
    cnt = rf_write_count;
    tick(); tick(); tick();
    check("rst no writes", rf_write_count - cnt, 0);
    launch(1'b0, 4'd0, 12'h020);
    check("rst restart mem_we", mem_write_enable, 1);
    check("rst restart addr", mem_addr, 12'h020);
    tick();
    check("rst restart done", done, 1);
    check("rst restart i_out", i_out, 12'h021);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chip8_reg_transfer.md
# chip8_reg_transfer

Sequencer for the CHIP-8 bulk register/memory instructions FX55 (store V0..Vx to memory at I) and FX65 (load V0..Vx from memory at I). Sits between the execute control and the 16×8 register file and the 4 KB main memory. It drives the register file's read and write ports and the memory port, one byte per cycle, and returns the updated I (I + x + 1).

## Interface
Parameters:
- ADDR_W, 12, memory address width; also the width of I.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- load  in  1  0 = store (FX55, regs→mem); 1 = load (FX65, mem→regs). Latched at start.
- last_reg  in  4  x, the highest register index to transfer. Latched at start.
- base_addr  in  ADDR_W  current I. Latched at start.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse in FINISH.
- i_out  out  ADDR_W  base + x + 1, modulo 2^ADDR_W. Valid while done is high.
- i_write_enable  out  1  equals done; the owner of I writes i_out when it is high.
- rf_read_select  out  4  drives the register file read select.
- rf_read_data  in  8  combinational register file read data.
- rf_write_enable  out  1  register file write strobe.
- rf_write_select  out  4  register file write index.
- rf_write_data  out  8  register file write data.
- mem_addr  out  ADDR_W  memory address.
- mem_write_enable  out  1  memory write strobe.
- mem_write_data  out  8  memory write data.
- mem_read_data  in  8  memory read data; synchronous read with 1-cycle latency.

## Operation
- States: IDLE, STORE, LOAD, LOAD_LAST, FINISH.
- IDLE: when start=1, latch load, last_reg and base_addr, clear idx to 0, and go to STORE (load=0) or LOAD (load=1).
- STORE: rf_read_select=idx, mem_addr=base+idx, mem_write_data=rf_read_data (combinational path), mem_write_enable=1. If idx==x go to FINISH, else increment idx.
- LOAD: mem_addr=base+idx. A pipeline valid bit tracks the address issued in the previous cycle. When the valid bit is set, drive rf_write_enable=1, rf_write_select=idx-1, rf_write_data=mem_read_data. If idx==x go to LOAD_LAST, else increment idx.
- LOAD_LAST: write Vx from mem_read_data, then go to FINISH.
- FINISH: done=1, i_write_enable=1, i_out=base+x+1, then go to IDLE.
- Address arithmetic is ADDR_W bits and wraps modulo 4096. No error is flagged on wrap.
- start is ignored outside IDLE, including in FINISH. Input changes after the start cycle have no effect.
- Reset (reset=0 at an edge): go to IDLE, clear idx and the pipeline valid bit. All outputs read 0: busy, done, i_write_enable, rf_write_enable, mem_write_enable, selects, data and addresses. No write strobe is asserted in the cycle after reset, even mid-transfer.
- In IDLE, every strobe is 0 and mem_addr and the selects are 0.

## Timing
- Start sampled at edge 0.
- Store: write of Vk to base+k happens in cycle k+1 for k=0..x. done is in cycle x+2. Total latency is x+2 cycles.
- Load: address base+k is issued in cycle k+1. Vk is written in cycle k+2. done is in cycle x+3.
- Throughput is one byte per cycle. There are no bubbles between bytes.
- The earliest next start is sampled in the cycle after FINISH.

## Structure
- Shared package chip8_pkg holds ADDR_W=12, the register count of 16, and the state encodings (IDLE, STORE, LOAD, LOAD_LAST, FINISH).
- Single module; no sub-module is warranted. The address adder and the idx counter are inline.

## Test plan
- Store: V0..V3=11,22,33,44, x=3, base=0x300 → memory writes 0x300..0x303 in cycles 1–4 with data 11,22,33,44; done in cycle 5; i_out=0x304.
- Load: mem[0x200..0x202]=AA,BB,CC, x=2 → V0=AA in cycle 2, V1=BB in cycle 3, V2=CC in cycle 4; done in cycle 5; i_out=0x203. No rf write occurs in cycle 1.
- Wrap: store with x=3, base=0xFFE → addresses FFE, FFF, 000, 001; i_out=0x002.
- Extremes: x=0 store/load transfers exactly one byte (store done in cycle 2, load done in cycle 3). x=F load writes all 16 registers; done in cycle 18.
- Start pulsed while busy or in FINISH → ignored; no second transfer occurs and the latched values are unchanged.
- reset=0 in cycle 3 of an x=5 load → next cycle is IDLE with all outputs 0 and no further rf writes; a new start afterwards completes normally.
